writeback_queue: RTL and testbench

Write-port owner for the 64-bit, 32-entry integer register file. Merges single-cycle ALU results and variable-latency load results into the file's one write port (WriteData/RD/RegWrite), buffering loads in a small FIFO so the ALU never stalls. Tracks registers with queued load writes for the decode-stage hazard logic, and cancels stale queued writes overtaken by younger ALU writes to the same register.

---
 rtl/writeback_queue.sv | 112 +++++++++++
 tb/tb_writeback_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Write-port owner for the integer register file: merges single-cycle ALU
// results with FIFO-buffered load results, tracks pending load targets and kills stale loads.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [XLEN-1:0]          ld_data,
    output logic                     RegWrite,
    output logic [4:0]               RD,
    output logic [XLEN-1:0]          WriteData,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [DEPTH-1:0] live;
    logic [4:0]       rd_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    logic full;
    logic empty;
    logic alu_issue;
    logic push;
    logic pop;
    logic head_live;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign ld_ready  = !Reset && !full;
    assign alu_issue = alu_valid && (alu_rd != 5'd0);
    // Loads to x0 complete the handshake but are dropped here.
    assign push      = ld_valid && ld_ready && (ld_rd != 5'd0);
    assign pop       = !alu_issue && !empty;
    assign head_live = live[head];

    // Occupancy, pointers and live bits. Statement order matters: a fresh push
    // must override the kill loop, since its liveness is decided explicitly.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            live  <= '0;
        end else begin
            if (alu_issue) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rd_q[i] == alu_rd) live[i] <= 1'b0;
                end
            end
            if (pop) begin
                live[head] <= 1'b0;
                head       <= head + 1'b1;
            end
            if (push) begin
                // A load accepted alongside an ALU write to the same register is older, so it is dead on arrival.
                live[tail] <= !(alu_issue && (ld_rd == alu_rd));
                tail       <= tail + 1'b1;
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    // NOTE: payload storage is deliberately not reset; live bits gate every use of it.
    always_ff @(posedge Clk) begin
        if (push) begin
            rd_q[tail]   <= ld_rd;
            data_q[tail] <= ld_data;
        end
    end

    // Registered write port; address and data hold while RegWrite is low.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RegWrite  <= 1'b0;
            RD        <= 5'd0;
            WriteData <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (alu_issue) begin
                RegWrite  <= 1'b1;
                RD        <= alu_rd;
                WriteData <= alu_data;
            end else if (pop && head_live) begin
                RegWrite  <= 1'b1;
                RD        <= rd_q[head];
                WriteData <= data_q[head];
            end
        end
    end

    // NOTE: combinational outputs get a default first so no latch is inferred.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) pending[rd_q[i]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: vector table plus hand sequences,
// with a scoreboard of expected register-file writes checked by a write monitor.
module tb_writeback_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic            alu_valid = 1'b0;
    logic [4:0]      alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            ld_valid = 1'b0;
    logic            ld_ready;
    logic [4:0]      ld_rd = '0;
    logic [XLEN-1:0] ld_data = '0;
    logic            RegWrite;
    logic [4:0]      RD;
    logic [XLEN-1:0] WriteData;
    logic [31:0]     pending;
    logic [$clog2(DEPTH):0] count;

    writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .Clk(Clk), .Reset(Reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
        .pending(pending), .count(count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic        alu_v;
        logic [4:0]  a_rd;
        logic [63:0] a_d;
        logic        ld_v;
        logic [4:0]  l_rd;
        logic [63:0] l_d;
        logic        exp_ready;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [63:0] exp_data;
        int          exp_count;
        logic [31:0] exp_pending;
    } vec_t;

    wr_t  sb[$];
    wr_t  mon_e;
    vec_t vecs[10];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [63:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        sb.push_back(w);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    // Every write the register file would capture must match the scoreboard head.
    always @(negedge Clk) begin
        if (!Reset && RegWrite) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write", RD, WriteData);
            end else begin
                mon_e = sb.pop_front();
                check("sb_rd", 64'(RD), 64'(mon_e.rd));
                check("sb_data", WriteData, mon_e.data);
            end
        end
    end

    initial begin
        //            alu_v rd  data        ld_v rd  data      rdy we rd  data        cnt pending
        vecs[0] = '{1'b0, 5'd0, 64'h0,      1'b1, 5'd5, 64'hA,  1'b1, 1'b0, 5'd0, 64'h0,      1, 32'h0000_0020};
        vecs[1] = '{1'b0, 5'd0, 64'h0,      1'b1, 5'd6, 64'hB,  1'b1, 1'b1, 5'd5, 64'hA,      1, 32'h0000_0040};
        vecs[2] = '{1'b0, 5'd0, 64'h0,      1'b0, 5'd0, 64'h0,  1'b1, 1'b1, 5'd6, 64'hB,      0, 32'h0};
        vecs[3] = '{1'b0, 5'd0, 64'h0,      1'b0, 5'd0, 64'h0,  1'b1, 1'b0, 5'd6, 64'hB,      0, 32'h0};
        vecs[4] = '{1'b1, 5'd3, 64'h1234,   1'b0, 5'd0, 64'h0,  1'b1, 1'b1, 5'd3, 64'h1234,   0, 32'h0};
        vecs[5] = '{1'b1, 5'd0, 64'h99,     1'b1, 5'd0, 64'h77, 1'b1, 1'b0, 5'd3, 64'h1234,   0, 32'h0};
        vecs[6] = '{1'b1, 5'd0, 64'h98,     1'b0, 5'd0, 64'h0,  1'b1, 1'b0, 5'd3, 64'h1234,   0, 32'h0};
        vecs[7] = '{1'b1, 5'd4, 64'h55,     1'b1, 5'd8, 64'h66, 1'b1, 1'b1, 5'd4, 64'h55,     1, 32'h0000_0100};
        vecs[8] = '{1'b1, 5'd0, 64'h97,     1'b0, 5'd0, 64'h0,  1'b1, 1'b1, 5'd8, 64'h66,     0, 32'h0};
        vecs[9] = '{1'b0, 5'd0, 64'h0,      1'b0, 5'd0, 64'h0,  1'b1, 1'b0, 5'd8, 64'h66,     0, 32'h0};

        // Reset state.
        #2;
        check("rst_regwrite", 64'(RegWrite), 64'd0);
        check("rst_rd", 64'(RD), 64'd0);
        check("rst_wdata", WriteData, 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_ready", 64'(ld_ready), 64'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b0;
        #1 check("rel_ready", 64'(ld_ready), 64'd1);

        // Table: load-only latency, hold behaviour, x0 filtering, ALU x0 with FIFO pop.
        for (int i = 0; i < 10; i++) begin
            alu_valid = vecs[i].alu_v;
            alu_rd    = vecs[i].a_rd;
            alu_data  = vecs[i].a_d;
            ld_valid  = vecs[i].ld_v;
            ld_rd     = vecs[i].l_rd;
            ld_data   = vecs[i].l_d;
            if (vecs[i].exp_we) expect_wr(vecs[i].exp_rd, vecs[i].exp_data);
            #1 check($sformatf("v%0d_ready", i), 64'(ld_ready), 64'(vecs[i].exp_ready));
            tick();
            check($sformatf("v%0d_we", i), 64'(RegWrite), 64'(vecs[i].exp_we));
            check($sformatf("v%0d_rd", i), 64'(RD), 64'(vecs[i].exp_rd));
            check($sformatf("v%0d_data", i), WriteData, vecs[i].exp_data);
            check($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
            check($sformatf("v%0d_pending", i), 64'(pending), 64'(vecs[i].exp_pending));
        end

        // Priority and full: 8 ALU cycles, 6 loads offered, only 4 fit.
        for (int k = 1; k <= 8; k++) begin
            alu_valid = 1'b1;
            alu_rd    = 5'(k);
            alu_data  = 64'h100 + 64'(k);
            expect_wr(5'(k), 64'h100 + 64'(k));
            ld_valid  = (k <= 6);
            ld_rd     = 5'(16 + k);
            ld_data   = 64'h200 + 64'(k);
            #1;
            if (k <= 6) check($sformatf("full_ready%0d", k), 64'(ld_ready), 64'(k <= 4));
            tick();
        end
        idle();
        #1;
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(ld_ready), 64'd0);
        check("full_pending", 64'(pending), 64'h001E_0000);
        for (int k = 1; k <= 4; k++) expect_wr(5'(16 + k), 64'h200 + 64'(k));
        for (int k = 0; k < 5; k++) tick();
        check("drain_count", 64'(count), 64'd0);
        check("drain_pending", 64'(pending), 64'd0);
        check("drain_sb", 64'(sb.size()), 64'd0);

        // Kill: queued load overtaken by a younger ALU write.
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 64'h11;
        tick();
        check("kill_pend_set", 64'(pending[7]), 64'd1);
        check("kill_count1", 64'(count), 64'd1);
        ld_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h22;
        expect_wr(5'd7, 64'h22);
        tick();
        check("kill_we", 64'(RegWrite), 64'd1);
        check("kill_data", WriteData, 64'h22);
        check("kill_pend_clr", 64'(pending[7]), 64'd0);
        check("kill_count_after", 64'(count), 64'd1);
        idle();
        tick();
        check("kill_pop_we", 64'(RegWrite), 64'd0);
        check("kill_pop_count", 64'(count), 64'd0);

        // Simultaneous kill: same-edge load and ALU to x9.
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h44;
        ld_valid  = 1'b1; ld_rd  = 5'd9; ld_data  = 64'h33;
        expect_wr(5'd9, 64'h44);
        tick();
        check("sim_we", 64'(RegWrite), 64'd1);
        check("sim_rd", 64'(RD), 64'd9);
        check("sim_data", WriteData, 64'h44);
        check("sim_count1", 64'(count), 64'd1);
        check("sim_pending", 64'(pending), 64'd0);
        idle();
        tick();
        check("sim_pop_we", 64'(RegWrite), 64'd0);
        check("sim_count0", 64'(count), 64'd0);
        tick();

        // Reset mid-operation with three loads queued behind ALU traffic.
        for (int k = 1; k <= 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(k); alu_data = 64'h300 + 64'(k);
            ld_valid  = 1'b1; ld_rd  = 5'(9 + k); ld_data = 64'h400 + 64'(k);
            expect_wr(5'(k), 64'h300 + 64'(k));
            tick();
        end
        idle();
        check("mid_count3", 64'(count), 64'd3);
        check("mid_pending", 64'(pending), 64'h0000_1C00);
        @(negedge Clk);
        #1 Reset = 1'b1;
        #1;
        check("mid_rst_we", 64'(RegWrite), 64'd0);
        check("mid_rst_rd", 64'(RD), 64'd0);
        check("mid_rst_data", WriteData, 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_pending", 64'(pending), 64'd0);
        check("mid_rst_ready", 64'(ld_ready), 64'd0);
        #1 Reset = 1'b0;
        #1 check("mid_rel_ready", 64'(ld_ready), 64'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("post_rst_we%0d", k), 64'(RegWrite), 64'd0);
        end
        check("post_rst_count", 64'(count), 64'd0);
        check("final_sb", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
